// File: rtl/pixel_readback.sv
// pixel_readback: shadow frame store on the drawer pixel-write bus.
// Captures every in-range drawer write, sweeps the whole store to CLEAR_COLOUR
// after reset or on clr_start, and answers single-cycle-latency colour reads
// for the collision logic. Out-of-range reads return WALL_COLOUR.
//
// Optional feature macro: PIXEL_READBACK_FWD_EN
//   defined   : a same-cycle write and read of one address returns the new colour
//   undefined : such a read returns the colour stored before the write
//
// Ports:
//   clk        system clock
//   resetn     synchronous active-low reset
//   wr_x/wr_y  pixel write coordinates
//   wr_colour  pixel write colour
//   wr_en      pixel write strobe
//   rd_req     read request, accepted when rd_req & rd_ready
//   rd_x/rd_y  read coordinates
//   rd_ready   high in idle; reads are refused during a clear sweep
//   rd_valid   one-cycle pulse the cycle after an accepted read
//   rd_colour  colour read back; holds its value while rd_valid is low
//   clr_start  request a full clear sweep (ignored while busy)
//   busy       clear sweep in progress
module pixel_readback #(
  parameter int unsigned WIDTH        = 160,
  parameter int unsigned HEIGHT       = 120,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000,
  parameter logic [2:0]  WALL_COLOUR  = 3'b111
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] wr_x,
  input  logic [9:0] wr_y,
  input  logic [2:0] wr_colour,
  input  logic       wr_en,
  input  logic       rd_req,
  input  logic [9:0] rd_x,
  input  logic [9:0] rd_y,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [2:0] rd_colour,
  input  logic       clr_start,
  output logic       busy
);

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned DEPTH    = WIDTH * HEIGHT;
  localparam int unsigned ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

`ifdef PIXEL_READBACK_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // Linear address y*WIDTH + x; the constant multiply reduces to (y<<7)+(y<<5)+x
  // for the default 160-pixel width.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
  endfunction

  logic [0:0]          state, state_next;
  logic [ADDR_W-1:0]   clr_addr, clr_addr_next;
  logic [COLOUR_W-1:0] mem [DEPTH];

  logic                wr_in_range, rd_in_range;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic                wr_hit, rd_accept, fwd_hit;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [COLOUR_W-1:0] mem_wdata;

  // Address decode and range checks; out-of-range coordinates never touch memory.
  assign wr_in_range = (wr_x < COORD_W'(WIDTH)) && (wr_y < COORD_W'(HEIGHT));
  assign rd_in_range = (rd_x < COORD_W'(WIDTH)) && (rd_y < COORD_W'(HEIGHT));
  assign wr_addr     = pix_addr(wr_x, wr_y);
  assign rd_addr     = pix_addr(rd_x, rd_y);
  assign wr_hit      = (state == S_IDLE) && wr_en && wr_in_range;
  assign rd_accept   = rd_req && rd_ready;
  assign fwd_hit     = FWD_EN && wr_hit && rd_in_range && (wr_addr == rd_addr);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  // Next-state logic and memory write-port steering.
  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    mem_we        = 1'b0;
    mem_waddr     = wr_addr;
    mem_wdata     = wr_colour;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = CLEAR_COLOUR;
      if (clr_addr == LAST_ADDR) begin
        state_next = S_IDLE;
      end else begin
        clr_addr_next = clr_addr + ADDR_W'(1);
      end
    end else begin
      mem_we = wr_hit;
      if (clr_start) begin
        state_next    = S_CLEAR;
        clr_addr_next = '0;
      end
    end
  end

  // Frame store write port; the sweep owns it while busy, drawers otherwise.
  always_ff @(posedge clk) begin
    if (resetn && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered outputs. The memory read samples pre-write contents, so without
  // forwarding a colliding read sees the old colour while the write still lands.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy      <= 1'b1;
      rd_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_colour <= '0;
    end else begin
      busy     <= (state_next == S_CLEAR);
      rd_ready <= (state_next == S_IDLE);
      rd_valid <= rd_accept;
      if (rd_accept) begin
        if (!rd_in_range) begin
          rd_colour <= WALL_COLOUR;
        end else if (fwd_hit) begin
          rd_colour <= wr_colour;
        end else begin
          rd_colour <= mem[rd_addr];
        end
      end
    end
  end

endmodule

// File: doc/pixel_readback.md
Name: pixel_readback

Overview:
- Shadow frame store on the receiving end of the drawer pixel-write stream (x, y, colour, writeEn).
- Captures every accepted pixel write from the platform, ball and brick drawers.
- Provides a request/valid read port so collision logic can read back the colour at any (x, y).
- Sits beside the VGA adapter on the same write bus. It is the reader for the drawers' writer.

Parameters:
- WIDTH, 160, screen width in pixels; valid x is 0..WIDTH-1.
- HEIGHT, 120, screen height in pixels; valid y is 0..HEIGHT-1.
- CLEAR_COLOUR, 3'b000, colour written to every location during a clear sweep.
- WALL_COLOUR, 3'b111, colour returned for any out-of-range read.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- wr_x  in  10  pixel write x
- wr_y  in  10  pixel write y
- wr_colour  in  3  pixel write colour
- wr_en  in  1  pixel write strobe (drawer writeEn)
- rd_req  in  1  read request
- rd_x  in  10  read x
- rd_y  in  10  read y
- rd_ready  out  1  read request accepted this cycle when rd_req&rd_ready
- rd_valid  out  1  one-cycle pulse, rd_colour valid
- rd_colour  out  3  colour read back
- clr_start  in  1  request full clear sweep
- busy  out  1  clear sweep in progress

Behaviour:
- Reset and clock: reset resetn, synchronous, active-low; clock clk.
- Reset values: state=S_CLEAR, clear address=0, busy=1, rd_ready=0, rd_valid=0, rd_colour=3'b000.
- Storage: WIDTH*HEIGHT x 3-bit memory.
  - addr = y*WIDTH + x. With defaults this is computed as (y<<7)+(y<<5)+x, 15 bits wide.
- FSM states:
  - S_CLEAR: writes CLEAR_COLOUR at clear address, then increments it by 1 each cycle. At address WIDTH*HEIGHT-1 the write completes and the FSM goes to S_IDLE next cycle. busy=1, rd_ready=0.
  - S_IDLE: busy=0, rd_ready=1. clr_start=1 resets clear address to 0 and goes to S_CLEAR. A read accepted in the same cycle as clr_start still completes.
- Clear duration: 19200 cycles with defaults. busy falls in the cycle after the last clear write.
- Writes:
  - In S_IDLE, wr_en=1 with wr_x<WIDTH and wr_y<HEIGHT writes wr_colour at the clock edge.
  - Out-of-range writes are silently dropped.
  - All drawer writes are dropped while busy=1.
- Reads:
  - Accepted in cycle N when rd_req&rd_ready.
  - rd_valid=1 for exactly cycle N+1 with rd_colour; rd_valid=0 otherwise.
  - rd_colour holds its last value when rd_valid=0.
  - One read may be accepted per cycle, so back-to-back reads give rd_valid high on consecutive cycles.
- Out-of-range read (rd_x>=WIDTH or rd_y>=HEIGHT): no memory access; rd_valid at N+1 with rd_colour=WALL_COLOUR.
- Simultaneous write and read of the same in-range address in cycle N: resolved per the Optional Feature section.
- Simultaneous write and read of different addresses: both take effect.
- Reset mid-clear or mid-read: rd_valid is deasserted and the clear restarts from address 0. Memory contents are not guaranteed until the new sweep completes.
- clr_start while busy: ignored. No restart, no extension.

Optional Feature:
- Macro: PIXEL_READBACK_FWD_EN.
- Defined: same-cycle same-address write/read returns the new wr_colour at N+1 (write-to-read forwarding).
- Not defined: the read returns the colour stored before the write (read-before-write). The write still lands.

Test Plan:
- Reset sequence: assert resetn=0 for 2 cycles, then release -> busy=1 for exactly 19200 cycles, then busy=0 and rd_ready=1. A read of (159,119) returns 3'b000.
- Write then read: write (32,110) colour 3'b100; next cycle read (32,110) -> rd_valid one cycle later with rd_colour=3'b100. A read of (33,110) returns 3'b000.
- Out of range:
  - Write (160,5) colour 3'b010 -> a read of (0,6) still returns 3'b000 (no wrap-around aliasing).
  - Read (5,120) -> rd_colour=3'b111 with rd_valid.
- Same-cycle collision: (40,40) holds 3'b001; in one cycle write 3'b100 and read (40,40) -> rd_colour=3'b100 with PIXEL_READBACK_FWD_EN, 3'b001 without. A following read returns 3'b100 in both builds.
- Clear and busy:
  - Fill (10,10) with 3'b110; pulse clr_start -> busy=1 for 19200 cycles.
  - A write to (10,10) of 3'b011 during busy is dropped; rd_ready=0 throughout.
  - After the sweep, a read of (10,10) returns 3'b000.
- Reset mid-clear and back-to-back reads:
  - Assert resetn=0 at clear cycle 5000 -> busy remains 1, then the full 19200-cycle sweep reruns.
  - Issue 3 consecutive reads afterwards -> 3 consecutive rd_valid pulses with correct colours.
